ipml_reg_fifo_v1_1_rd_unpack: RTL and testbench

//  Read-data unpacker sitting directly downstream of the 2-entry read register FIFO.

---
 rtl/ipml_reg_fifo_v1_1_rd_unpack_if.sv | 30 +++
 rtl/ipml_reg_fifo_v1_1_rd_unpack.sv | 121 ++++++++++++
 tb/tb_ipml_reg_fifo_v1_1_rd_unpack.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ipml_reg_fifo_v1_1_rd_unpack_if.sv
// Handshake bundle for the read-data unpacker: burst command, wide word input,
// narrow beat output and a busy flag. The DUT connects through the slave modport,
// its environment through the master modport.
interface ipml_reg_fifo_v1_1_rd_unpack_if #(
    parameter int W_OUT = 8,
    parameter int RATIO = 4,
    parameter int LEN_W = 8
);
    logic                     cmd_valid;
    logic [LEN_W-1:0]         cmd_len;
    logic                     cmd_ready;
    logic                     s_valid;
    logic [W_OUT*RATIO-1:0]   s_data;
    logic                     s_ready;
    logic                     m_valid;
    logic [W_OUT-1:0]         m_data;
    logic                     m_last;
    logic                     m_ready;
    logic                     busy;

    modport slave (
        input  cmd_valid, cmd_len, s_valid, s_data, m_ready,
        output cmd_ready, s_ready, m_valid, m_data, m_last, busy
    );

    modport master (
        output cmd_valid, cmd_len, s_valid, s_data, m_ready,
        input  cmd_ready, s_ready, m_valid, m_data, m_last, busy
    );
endinterface

// File: rtl/ipml_reg_fifo_v1_1_rd_unpack.sv
// Read-data unpacker: splits wide FIFO words into RATIO narrow lanes (lane 0
// first) and emits exactly cmd_len+1 beats per burst, flagging the final beat.
// Data path is a zero-latency combinational lane mux; only the lane index,
// remaining-beat count and IDLE/XFER state are registered. Tail lanes of the
// last word of a burst are discarded by popping that word on the final beat.
module ipml_reg_fifo_v1_1_rd_unpack #(
    parameter int W_OUT = 8,
    parameter int RATIO = 4,
    parameter int LEN_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    ipml_reg_fifo_v1_1_rd_unpack_if.slave bus
);

    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(RATIO - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [LANE_W-1:0] r_lane;
    logic [LANE_W-1:0] w_lane_next;
    logic [LEN_W-1:0]  r_beat_rem;
    logic [LEN_W-1:0]  w_beat_rem_next;

    logic [W_OUT-1:0]  w_lane_data [RATIO];
    logic [W_OUT-1:0]  w_m_data;
    logic              w_last_beat;
    logic              w_last_lane;
    logic              w_cmd_ready;
    logic              w_s_ready;
    logic              w_m_valid;
    logic              w_m_last;
    logic              w_busy;

    // Split the wide word into its lanes.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            assign w_lane_data[gi] = bus.s_data[gi*W_OUT +: W_OUT];
        end
    endgenerate

    assign w_last_beat = (r_beat_rem == '0);
    assign w_last_lane = (r_lane == LANE_MAX);

    // State, lane and remaining-beat registers; reset abandons any burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lane     <= '0;
            r_beat_rem <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lane     <= w_lane_next;
            r_beat_rem <= w_beat_rem_next;
        end
    end

    // Next-state and handshake outputs; lane mux selects the current beat.
    always_comb begin
        w_state_next    = r_state;
        w_lane_next     = r_lane;
        w_beat_rem_next = r_beat_rem;
        w_cmd_ready     = 1'b0;
        w_s_ready       = 1'b0;
        w_m_valid       = 1'b0;
        w_m_last        = 1'b0;
        w_busy          = 1'b0;
        w_m_data        = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (r_lane == LANE_W'(k)) begin
                w_m_data = w_lane_data[k];
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_beat_rem_next = bus.cmd_len;
                    w_lane_next     = '0;
                    w_state_next    = ST_XFER;
                end
            end
            ST_XFER: begin
                w_busy    = 1'b1;
                w_m_valid = bus.s_valid;
                w_m_last  = w_last_beat;
                // Pop the word on its last lane, or early on the burst's last beat.
                w_s_ready = bus.m_ready & (w_last_lane | w_last_beat);
                if (bus.s_valid && bus.m_ready) begin
                    if (w_last_beat) begin
                        w_state_next = ST_IDLE;
                        w_lane_next  = '0;
                    end else begin
                        w_beat_rem_next = r_beat_rem - 1'b1;
                        w_lane_next     = w_last_lane ? '0 : r_lane + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Control outputs are held low while reset is asserted.
    assign bus.cmd_ready = rst_n & w_cmd_ready;
    assign bus.s_ready   = rst_n & w_s_ready;
    assign bus.m_valid   = rst_n & w_m_valid;
    assign bus.m_last    = rst_n & w_m_last;
    assign bus.busy      = rst_n & w_busy;
    assign bus.m_data    = w_m_data;

endmodule

// File: tb/tb_ipml_reg_fifo_v1_1_rd_unpack.sv
// Randomized bench for the read-data unpacker. A word stream emulates the
// upstream FIFO; each accepted command is expanded into its expected beat list
// (bytes of consecutive words, last flag, word-pop points) and every output is
// compared against that list cycle by cycle.
module tb_ipml_reg_fifo_v1_1_rd_unpack;

    localparam int W_OUT = 8;
    localparam int RATIO = 4;
    localparam int LEN_W = 8;
    localparam int W_IN  = W_OUT * RATIO;

    typedef struct {
        logic [W_OUT-1:0] data;
        logic             last;
        logic             pop;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ipml_reg_fifo_v1_1_rd_unpack_if #(.W_OUT(W_OUT), .RATIO(RATIO), .LEN_W(LEN_W)) bus ();

    ipml_reg_fifo_v1_1_rd_unpack #(.W_OUT(W_OUT), .RATIO(RATIO), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [W_IN-1:0] stream [$];
    int    head      = 0;
    beat_t exp_q [$];
    bit    mdl_busy  = 1'b0;
    int    exp_end   = 0;
    int    n_bursts  = 0;

    int p_sv  = 100;
    int p_mr  = 100;
    int p_cmd = 100;
    int p_rst = 0;
    int fixed_len = -1;
    bit force_rst = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rand_len();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 4)  return (1 << LEN_W) - 1;
        if (r < 20) return int'($urandom_range(0, 3));
        return int'($urandom_range(0, 40));
    endfunction

    // Expand a command into the beats the unpacker must produce.
    task automatic start_burst(input int len);
        int n, nw;
        logic [W_IN-1:0] w;
        beat_t b;
        n  = len + 1;
        nw = (n + RATIO - 1) / RATIO;
        while (stream.size() < head + nw) stream.push_back(W_IN'($urandom));
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            w      = stream[head + k / RATIO];
            b.data = w[(k % RATIO)*W_OUT +: W_OUT];
            b.last = (k == n - 1);
            b.pop  = ((k % RATIO) == RATIO - 1) || (k == n - 1);
            exp_q.push_back(b);
        end
        exp_end  = head + nw;
        mdl_busy = 1'b1;
        n_bursts++;
    endtask

    task automatic step();
        bit hs, pop_word;
        @(negedge clk);
        rst_n = (force_rst || (int'($urandom_range(0, 999)) < p_rst)) ? 1'b0 : 1'b1;
        while (stream.size() <= head) stream.push_back(W_IN'($urandom));
        bus.s_valid   = (int'($urandom_range(0, 99)) < p_sv);
        bus.s_data    = stream[head];
        bus.m_ready   = (int'($urandom_range(0, 99)) < p_mr);
        bus.cmd_valid = (int'($urandom_range(0, 99)) < p_cmd);
        bus.cmd_len   = LEN_W'((fixed_len >= 0) ? fixed_len : rand_len());
        #1;
        pop_word = rst_n && bus.s_valid && bus.s_ready;
        if (!rst_n) begin
            check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
            check("rst_s_ready",   64'(bus.s_ready),   64'(0));
            check("rst_m_valid",   64'(bus.m_valid),   64'(0));
            check("rst_m_last",    64'(bus.m_last),    64'(0));
            check("rst_busy",      64'(bus.busy),      64'(0));
            mdl_busy = 1'b0;
            exp_q.delete();
        end else if (!mdl_busy) begin
            check("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));
            check("idle_busy",      64'(bus.busy),      64'(0));
            check("idle_m_valid",   64'(bus.m_valid),   64'(0));
            check("idle_s_ready",   64'(bus.s_ready),   64'(0));
            if (bus.cmd_valid) start_burst(int'(bus.cmd_len));
        end else begin
            check("xfer_cmd_ready", 64'(bus.cmd_ready), 64'(0));
            check("xfer_busy",      64'(bus.busy),      64'(1));
            check("xfer_m_valid",   64'(bus.m_valid),   64'(bus.s_valid));
            if (exp_q.size() == 0) begin
                check("beats_left", 64'(0), 64'(1));
                mdl_busy = 1'b0;
            end else begin
                check("s_ready", 64'(bus.s_ready), 64'(bus.m_ready && exp_q[0].pop));
                if (bus.m_valid) begin
                    check("m_data", 64'(bus.m_data), 64'(exp_q[0].data));
                    check("m_last", 64'(bus.m_last), 64'(exp_q[0].last));
                end
                hs = bus.m_valid && bus.m_ready;
                if (hs) begin
                    $display("beat %0d data %02h last %0b", n_bursts, bus.m_data, bus.m_last);
                    if (exp_q[0].last) begin
                        mdl_busy = 1'b0;
                        check("words_popped", 64'(head + (pop_word ? 1 : 0)), 64'(exp_end));
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
        if (pop_word) head++;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b0;
        stream.push_back(32'h03020100);
        stream.push_back(32'h07060504);
        stream.push_back(32'h0B0A0908);
        stream.push_back(32'h0F0E0D0C);

        // Reset state.
        force_rst = 1'b1;
        repeat (2) step();
        force_rst = 1'b0;

        // Directed: full 8-beat burst over two words, then a 6-beat one.
        fixed_len = 7; p_cmd = 100;
        step();
        p_cmd = 0;
        repeat (8) step();
        fixed_len = 5; p_cmd = 100;
        step();
        p_cmd = 0;
        repeat (6) step();
        fixed_len = 0; p_cmd = 100;
        step();
        p_cmd = 0;
        repeat (2) step();

        // Randomized traffic with varying pressure and occasional resets.
        fixed_len = -1;
        for (int phase = 0; phase < 16; phase++) begin
            p_sv  = int'($urandom_range(30, 100));
            p_mr  = int'($urandom_range(30, 100));
            p_cmd = int'($urandom_range(20, 100));
            p_rst = (phase % 4 == 3) ? 5 : 0;
            repeat (250) step();
        end

        // Drain any open burst.
        p_cmd = 0; p_rst = 0; p_sv = 100; p_mr = 100;
        repeat (300) step();
        check("drained_busy", 64'(bus.busy), 64'(0));
        check("drained_model", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
